// File: rtl/io_dev_decoder.sv
// Registered I/O bus fan-out decoder: one-hot device select, ack/data return mux, auto-response for dead slots.
// Optional ACCESS-state ack timeout is built when IO_DEV_TIMEOUT_EN is defined.
module io_dev_decoder #(
  parameter int          NDEV      = 16,
  parameter logic [15:0] DEV_EN    = 16'hFFFF,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] DEAD_DATA = 32'hDEADDEAD
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  output logic                 s_ack_o,
  input  logic                 s_we_i,
  input  logic [3:0]           s_sel_i,
  input  logic [31:0]          s_adr_i,
  input  logic [31:0]          s_dat_i,
  output logic [31:0]          s_dat_o,
  output logic [NDEV-1:0]      cs_o,
  output logic                 m_cyc_o,
  output logic                 m_stb_o,
  output logic                 m_we_o,
  output logic [3:0]           m_sel_o,
  output logic [15:0]          m_adr_o,
  output logic [31:0]          m_dat_o,
  input  logic [NDEV-1:0]      dev_ack_i,
  input  logic [32*NDEV-1:0]   dev_dat_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DEAD, HOLD} state_e;

  state_e           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic             s_ack_q, s_ack_d;
  logic [31:0]      s_dat_q, s_dat_d;
  logic [NDEV-1:0]  cs_q, cs_d;
  logic             m_cyc_q, m_cyc_d;
  logic             m_stb_q, m_stb_d;
  logic             m_we_q, m_we_d;
  logic [3:0]       m_sel_q, m_sel_d;
  logic [15:0]      m_adr_q, m_adr_d;
  logic [31:0]      m_dat_q, m_dat_d;
`ifdef IO_DEV_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
`endif

  logic [3:0]       req_slot;
  logic             req_ok;
  logic [NDEV-1:0]  req_onehot;
  logic             sel_ack;
  logic [31:0]      sel_dat;
  logic             unused_adr;

  assign req_slot   = s_adr_i[19:16];
  assign req_ok     = (int'(req_slot) < NDEV) && DEV_EN[req_slot];
  assign unused_adr = ^s_adr_i[31:20];

  always_comb begin
    req_onehot = '0;
    sel_ack    = 1'b0;
    sel_dat    = '0;
    for (int i = 0; i < NDEV; i++) begin
      req_onehot[i] = (req_slot == 4'(i));
      if (slot_q == 4'(i)) begin
        sel_ack = dev_ack_i[i];
        sel_dat = dev_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    s_ack_d = s_ack_q;
    s_dat_d = s_dat_q;
    cs_d    = cs_q;
    m_cyc_d = m_cyc_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_sel_d = m_sel_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
`ifdef IO_DEV_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_cyc_i && s_stb_i && !s_ack_q) begin
          slot_d  = req_slot;
          m_we_d  = s_we_i;
          m_sel_d = s_sel_i;
          m_adr_d = s_adr_i[15:0];
          m_dat_d = s_dat_i;
`ifdef IO_DEV_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (req_ok) begin
            cs_d    = req_onehot;
            m_cyc_d = 1'b1;
            m_stb_d = 1'b1;
            state_d = ACCESS;
          end else begin
            state_d = DEAD;
          end
        end
      end
      ACCESS: begin
`ifdef IO_DEV_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        // Abort outranks a same-cycle ack so a dropped cycle is never acked.
        if (!s_cyc_i) begin
          cs_d    = '0;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          m_sel_d = '0;
          m_adr_d = '0;
          m_dat_d = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          s_ack_d = 1'b1;
          s_dat_d = m_we_q ? 32'h0 : sel_dat;
          cs_d    = '0;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          state_d = HOLD;
        end
`ifdef IO_DEV_TIMEOUT_EN
        else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          s_ack_d = 1'b1;
          s_dat_d = DEAD_DATA;
          cs_d    = '0;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          m_sel_d = '0;
          m_adr_d = '0;
          m_dat_d = '0;
          state_d = HOLD;
        end
`endif
      end
      DEAD: begin
        s_ack_d = 1'b1;
        s_dat_d = DEAD_DATA;
        state_d = HOLD;
      end
      HOLD: begin
        if (!s_stb_i) begin
          s_ack_d = 1'b0;
          s_dat_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      slot_q  <= '0;
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
      cs_q    <= '0;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_sel_q <= '0;
      m_adr_q <= '0;
      m_dat_q <= '0;
`ifdef IO_DEV_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      s_ack_q <= s_ack_d;
      s_dat_q <= s_dat_d;
      cs_q    <= cs_d;
      m_cyc_q <= m_cyc_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_sel_q <= m_sel_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
`ifdef IO_DEV_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign cs_o    = cs_q;
  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_stb_q;
  assign m_we_o  = m_we_q;
  assign m_sel_o = m_sel_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_io_dev_decoder.sv
// Self-checking bench for io_dev_decoder: vector table, hand-written corner sequences and randomized transactions.
// Twelve device slots, with the upper four enabled but out of range so they must behave as dead slots.
module tb_io_dev_decoder;

  localparam int          NDEV_P    = 12;
  localparam logic [15:0] DEV_EN_P  = 16'hF0FF;
  localparam int          TIMEOUT_P = 4;
  localparam logic [31:0] DEAD_P    = 32'hDEADDEAD;

  typedef struct {
    logic [3:0]        slot;
    logic              we;
    logic [3:0]        sel;
    logic [15:0]       off;
    logic [31:0]       dat;
    int                dly;
    int                hold;
    logic [NDEV_P-1:0] exp_cs;
    int                exp_k;
    logic [31:0]       exp_rdata;
  } vec_t;

  logic                clk;
  logic                rst_n;
  logic                s_cyc, s_stb, s_we;
  logic [3:0]          s_sel;
  logic [31:0]         s_adr, s_dat;
  logic                s_ack_o;
  logic [31:0]         s_dat_o;
  logic [NDEV_P-1:0]   cs_o;
  logic                m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]          m_sel_o;
  logic [15:0]         m_adr_o;
  logic [31:0]         m_dat_o;
  logic [NDEV_P-1:0]   dev_ack;
  logic [32*NDEV_P-1:0] dev_dat;

  int                  checks;
  int                  failures;
  int                  dly_cfg  [NDEV_P];
  int                  wcnt     [NDEV_P];
  logic [31:0]         dev_word [NDEV_P];
  logic [NDEV_P-1:0]   spur;
  vec_t                vecs [7];

  io_dev_decoder #(
    .NDEV(NDEV_P), .DEV_EN(DEV_EN_P), .TIMEOUT(TIMEOUT_P), .DEAD_DATA(DEAD_P)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_ack_o(s_ack_o), .s_we_i(s_we),
    .s_sel_i(s_sel), .s_adr_i(s_adr), .s_dat_i(s_dat), .s_dat_o(s_dat_o),
    .cs_o(cs_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .dev_ack_i(dev_ack), .dev_dat_i(dev_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each device acks once it has seen its select and strobe for dly_cfg cycles.
  always @(posedge clk) begin
    for (int i = 0; i < NDEV_P; i++)
      wcnt[i] <= (cs_o[i] && m_stb_o) ? wcnt[i] + 1 : 0;
  end

  always_comb begin
    dev_ack = '0;
    dev_dat = '0;
    for (int i = 0; i < NDEV_P; i++) begin
      dev_ack[i] = spur[i] | (cs_o[i] & m_stb_o & (wcnt[i] == dly_cfg[i]));
      dev_dat[32*i +: 32] = dev_word[i];
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: populated slots answer after the device delay, everything else answers as dead.
  function automatic vec_t modelExpect(input vec_t v);
    vec_t r;
    int s;
    logic populated;
    logic [NDEV_P-1:0] one;
    r = v;
    s = int'(v.slot);
    one = 1;
    populated = (s < NDEV_P) && DEV_EN_P[s];
    r.exp_cs    = populated ? (one << s) : '0;
    r.exp_k     = populated ? 1 + v.dly : 1;
    r.exp_rdata = !populated ? DEAD_P : (v.we ? 32'h0 : dev_word[s]);
    return r;
  endfunction

  task automatic driveRequest(input logic [3:0] slot, input logic we, input logic [3:0] sel,
                              input logic [15:0] off, input logic [31:0] dat);
    @(posedge clk); #1;
    s_cyc = 1'b1;
    s_stb = 1'b1;
    s_we  = we;
    s_sel = sel;
    s_adr = {12'hFD0, slot, off};
    s_dat = dat;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic got;
    logic stable;
    int k;
    if (int'(v.slot) < NDEV_P) dly_cfg[int'(v.slot)] = v.dly;
    driveRequest(v.slot, v.we, v.sel, v.off, v.dat);
    got = 1'b0;
    stable = 1'b1;
    k = -1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        checkOutput("cs", 32'(cs_o), 32'(v.exp_cs));
        checkOutput("m_stb_cyc", {30'h0, m_stb_o, m_cyc_o}, {30'h0, v.exp_cs != 0, v.exp_cs != 0});
        checkOutput("m_ctrl", {27'h0, m_we_o, m_sel_o}, {27'h0, v.we, v.sel});
        checkOutput("m_adr", 32'(m_adr_o), 32'(v.off));
        checkOutput("m_dat", m_dat_o, v.dat);
      end else if (!s_ack_o && (m_adr_o !== v.off || m_dat_o !== v.dat ||
                                m_sel_o !== v.sel || m_we_o !== v.we)) begin
        stable = 1'b0;
      end
      if (s_ack_o) begin
        got = 1'b1;
        k = c;
      end
    end
    checkOutput("ack_seen", 32'(got), 32'h1);
    checkOutput("latency", k, v.exp_k);
    checkOutput("rdata", s_dat_o, v.exp_rdata);
    checkOutput("stb_drop_at_ack", {30'h0, m_stb_o, m_cyc_o}, 32'h0);
    if (v.exp_k >= 2) checkOutput("m_stable", 32'(stable), 32'h1);
    repeat (v.hold) @(posedge clk);
    #1;
    checkOutput("hold", {s_ack_o, s_dat_o}, {1'b1, v.exp_rdata});
    s_stb = 1'b0;
    s_cyc = 1'b0;
    @(posedge clk); #1;
    checkOutput("release", {s_ack_o, s_dat_o}, 33'h0);
  endtask

  initial begin
    vec_t v;
    int k;
    checks   = 0;
    failures = 0;
    spur     = '0;
    rst_n    = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
    s_sel = '0; s_adr = '0; s_dat = '0;
    for (int i = 0; i < NDEV_P; i++) begin
      dly_cfg[i]  = 0;
      dev_word[i] = 32'hC0DE0000 | 32'(i);
    end
    dev_word[3] = 32'h12345678;

    vecs[0] = '{slot:4'd3,  we:1'b0, sel:4'hF, off:16'h0040, dat:32'h0,        dly:2, hold:2,
                exp_cs:12'h008, exp_k:3, exp_rdata:32'h12345678};
    vecs[1] = '{slot:4'd5,  we:1'b1, sel:4'h3, off:16'h0010, dat:32'hA5A50001, dly:1, hold:0,
                exp_cs:12'h020, exp_k:2, exp_rdata:32'h0};
    vecs[2] = '{slot:4'd9,  we:1'b0, sel:4'hF, off:16'h0004, dat:32'h0,        dly:0, hold:1,
                exp_cs:12'h000, exp_k:1, exp_rdata:32'hDEADDEAD};
    vecs[3] = '{slot:4'd0,  we:1'b0, sel:4'h1, off:16'hFFFC, dat:32'h0,        dly:0, hold:0,
                exp_cs:12'h001, exp_k:1, exp_rdata:32'hC0DE0000};
    vecs[4] = '{slot:4'd13, we:1'b0, sel:4'hF, off:16'h0100, dat:32'h0,        dly:0, hold:0,
                exp_cs:12'h000, exp_k:1, exp_rdata:32'hDEADDEAD};
    vecs[5] = '{slot:4'd10, we:1'b1, sel:4'hC, off:16'h0008, dat:32'h00001234, dly:0, hold:1,
                exp_cs:12'h000, exp_k:1, exp_rdata:32'hDEADDEAD};
    vecs[6] = '{slot:4'd7,  we:1'b0, sel:4'hF, off:16'h0020, dat:32'h0,        dly:1, hold:1,
                exp_cs:12'h080, exp_k:2, exp_rdata:32'hC0DE0007};

    #23;
    checkOutput("reset_ctrl", {26'h0, s_ack_o, m_cyc_o, m_stb_o, m_we_o, |m_sel_o, |cs_o}, 32'h0);
    checkOutput("reset_sdat", s_dat_o, 32'h0);
    checkOutput("reset_madr", 32'(m_adr_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Abort one cycle into ACCESS on slot 1, with stray acks around it.
    dly_cfg[1] = 99;
    driveRequest(4'd1, 1'b0, 4'hF, 16'h0030, 32'h0);
    @(posedge clk); #1;
    spur = 12'h001;
    @(posedge clk); #1;
    checkOutput("spurious_ignored", {30'h0, s_ack_o, m_stb_o}, 32'h1);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    spur  = 12'h002;
    @(posedge clk); #1;
    spur = '0;
    checkOutput("abort_ctrl", {28'h0, s_ack_o, m_cyc_o, m_stb_o, |cs_o}, 32'h0);
    checkOutput("abort_madr", 32'(m_adr_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_no_ack", 32'(s_ack_o), 32'h0);
    applyStimulus(vecs[3]);

    // Reset pulsed while holding an ack.
    dly_cfg[4] = 0;
    driveRequest(4'd4, 1'b0, 4'hF, 16'h0044, 32'h0);
    k = 0;
    while (!s_ack_o && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("rst_pre_ack", 32'(s_ack_o), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ctrl", {28'h0, s_ack_o, m_cyc_o, m_stb_o, |cs_o}, 32'h0);
    checkOutput("rst_async_data", s_dat_o | 32'(m_adr_o), 32'h0);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_no_ack", 32'(s_ack_o), 32'h0);
    applyStimulus(vecs[0]);

`ifdef IO_DEV_TIMEOUT_EN
    dly_cfg[2] = 99;
    driveRequest(4'd2, 1'b0, 4'hF, 16'h0000, 32'h0);
    k = -1;
    for (int c = 0; c < 20 && k < 0; c++) begin
      @(posedge clk); #1;
      if (c == TIMEOUT_P - 1) checkOutput("to_still_waiting", 32'(m_stb_o), 32'h1);
      if (s_ack_o) k = c;
    end
    checkOutput("to_latency", k, TIMEOUT_P);
    checkOutput("to_data", {s_dat_o, m_stb_o, m_cyc_o, |cs_o}, {DEAD_P, 3'b000});
    s_stb = 1'b0;
    s_cyc = 1'b0;
    @(posedge clk); #1;
    checkOutput("to_release", 32'(s_ack_o), 32'h0);
`endif

    for (int n = 0; n < 40; n++) begin
      v.slot = 4'($urandom_range(0, 15));
      v.we   = 1'($urandom);
      v.sel  = 4'($urandom);
      v.off  = 16'($urandom);
      v.dat  = $urandom;
      v.dly  = $urandom_range(0, 2);
      v.hold = $urandom_range(0, 2);
      if (int'(v.slot) < NDEV_P) dev_word[int'(v.slot)] = $urandom;
      applyStimulus(modelExpect(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_dev_decoder.md
Name: io_dev_decoder

Overview:
- Sits directly downstream of the I/O bridge master port and fans one registered 32-bit I/O bus out to up to 16 low-speed peripherals.
- Decodes a device slot from address bits, drives a one-hot chip select, and multiplexes the selected device's ack and read data back to the bridge.
- Answers dead or unpopulated slots itself so the bridge never hangs.
- Adds one register stage in each direction.

Parameters:
- NDEV, 16, number of device slots (1..16); slot index = s_adr_i[19:16].
- DEV_EN, 16'hFFFF, bit i = 1 means slot i is populated; unpopulated or out-of-range slots auto-respond.
- TIMEOUT, 255, cycles to wait for a device ack before a forced response (8-bit counter, 1..255).
- DEAD_DATA, 32'hDEADDEAD, read data returned on unpopulated-slot or timeout responses.

Ports:
- clk_i  in  1  bus clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_cyc_i  in  1  cycle from the bridge master port.
- s_stb_i  in  1  strobe from the bridge.
- s_ack_o  out  1  ack to the bridge (registered).
- s_we_i  in  1  write enable.
- s_sel_i  in  4  byte lane selects.
- s_adr_i  in  32  address (upper 12 bits are always FD0).
- s_dat_i  in  32  write data.
- s_dat_o  out  32  read data (registered).
- cs_o  out  NDEV  one-hot device select.
- m_cyc_o  out  1  shared cycle to devices.
- m_stb_o  out  1  shared strobe to devices.
- m_we_o  out  1  shared write enable.
- m_sel_o  out  4  shared byte lane selects.
- m_adr_o  out  16  device-local address, s_adr_i[15:0].
- m_dat_o  out  32  shared write data.
- dev_ack_i  in  NDEV  per-device ack.
- dev_dat_i  in  32*NDEV  per-device read data; slot i occupies bits [32i+31:32i].

Behaviour:
- Interface: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0; s_dat_o = 0; state = IDLE; timeout counter = 0.
- State IDLE:
  - Entered on s_cyc_i & s_stb_i with s_ack_o low.
  - Latches slot = s_adr_i[19:16].
  - Latches we, sel, adr[15:0] and dat into m_* outputs.
  - If slot < NDEV and DEV_EN[slot]: assert cs_o[slot], m_cyc_o, m_stb_o; go to ACCESS.
  - Otherwise: go to DEAD.
- State ACCESS:
  - Each cycle the timeout counter increments.
  - dev_ack_i[slot] = 1: capture dev_dat_i slot word into s_dat_o (write: capture 0); set s_ack_o; deassert m_stb_o, m_cyc_o, cs_o; go to HOLD.
  - Acks from non-selected slots are ignored.
  - s_cyc_i falls before an ack (abort): drop all m_* and cs_o next cycle, no ack; go to IDLE.
  - Ack and abort in the same cycle: abort wins.
- State DEAD: next cycle set s_ack_o, s_dat_o = DEAD_DATA (writes are discarded); go to HOLD.
- State HOLD:
  - s_ack_o and s_dat_o are held while s_stb_i = 1.
  - When s_stb_i = 0: clear s_ack_o and s_dat_o next cycle; go to IDLE.
  - A new request is not accepted until back in IDLE.
- Latency, read of a zero-wait device acking combinationally on strobe:
  - s_stb_i at edge N.
  - m_stb_o at N+1.
  - s_ack_o at N+2.
- Reset mid-operation: all outputs drop immediately; no ack is issued.
- Write data, sel and address are stable on m_* for the whole ACCESS state.

Optional Feature:
- Macro: IO_DEV_TIMEOUT_EN.
- Defined: in ACCESS, when the counter reaches TIMEOUT with no ack, force the DEAD response: s_ack_o next cycle, data DEAD_DATA, drop m_* and cs_o.
- Not defined: no counter is built; ACCESS waits indefinitely for the ack or an abort.

Test Plan:
- Read slot 3, dev 3 acks 2 cycles after m_stb_o with 32'h12345678 -> cs_o = 16'h0008; s_ack_o = 1 with s_dat_o = 32'h12345678 until s_stb_i falls, then 0 one cycle later.
- Write adr FD05_0010, sel 4'h3, dat 32'hA5A5_0001 -> cs_o[5]=1, m_adr_o = 16'h0010, m_sel_o = 4'h3, m_dat_o = 32'hA5A50001, m_we_o=1; ack returned.
- DEV_EN = 16'h00FF, read slot 9 -> no cs_o bit set; s_ack_o at N+2 with 32'hDEADDEAD.
- Timeout (macro on, TIMEOUT=4), slot 2 never acks -> m_stb_o drops and s_ack_o with DEAD_DATA after 4 ACCESS cycles.
- s_cyc_i dropped 1 cycle into ACCESS on slot 1, plus a spurious dev_ack_i[0] -> no s_ack_o; cs_o = 0 next cycle; next request serviced normally.
- rst_ni pulsed low during HOLD -> s_ack_o, cs_o and m_* go to 0 asynchronously; state returns to IDLE.
